// File: rtl/bcd_a_binario.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble, one bit per clock).
// Define BCD_VALIDATE_EN to reject digits > 9 up front (err output, IDLE->DONE fast path).
module bcd_a_binario #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_shift;
  logic [CNT_W-1:0]  cnt;
  logic              last_iter;
  logic              bad_digit;

  assign last_iter = (cnt == CNT_W'(BIN_W - 1));

  // One iteration: shift {bcd, bin} right, then pull any BCD digit >= 8 back by 3.
  always_comb begin
    sr_shift = sr >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr_shift[BIN_W + 4*d +: 4] >= 4'd8)
        sr_shift[BIN_W + 4*d +: 4] = sr_shift[BIN_W + 4*d +: 4] - 4'd3;
    end
  end

`ifdef BCD_VALIDATE_EN
  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9)
        bad_digit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == IDLE && start && bad_digit) begin
      err <= 1'b1;
    end else if (state == CONV && last_iter) begin
      err <= 1'b0;
    end
  end
`else
  assign bad_digit = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_nxt = bad_digit ? DONE : CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (last_iter)
          state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bin_out holds between conversions; only a finished or rejected request updates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      cnt     <= '0;
      bin_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr  <= {bcd_in, {BIN_W{1'b0}}};
            cnt <= '0;
            if (bad_digit)
              bin_out <= '0;
          end
        end
        CONV: begin
          sr  <= sr_shift;
          cnt <= cnt + CNT_W'(1);
          if (last_iter)
            bin_out <= sr_shift[BIN_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_a_binario.sv
// Scoreboard bench for bcd_a_binario: expectations queued at each accepted start, checked on done.
// Builds with or without BCD_VALIDATE_EN; invalid-digit expectations follow the macro.
module tb_bcd_a_binario;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
    logic             chk_bin;
    int               due;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [4*DIGITS-1:0] bcd_in;
  logic [BIN_W-1:0]    bin_out;
  logic                busy;
  logic                done;
  logic                err;

  exp_t sb[$];
  exp_t mon_item;
  int   cyc;
  int   n_compared;
  int   n_mismatched;
  logic prev_done;

  bcd_a_binario #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 3000) begin
      $display("[TB] FAIL watchdog: cycle %0d exceeded limit 3000", cyc);
      $fatal(1, "[TB] watchdog expired");
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Decimal reference: weighted digit sum, independent of the shift/adjust algorithm.
  function automatic exp_t expectedFor(input logic [4*DIGITS-1:0] bcd, input int k);
    exp_t e;
    logic bad;
    int   val;
    bad = 1'b0;
    val = 0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (bcd[4*d +: 4] > 4'd9) bad = 1'b1;
      val = val * 10 + int'(bcd[4*d +: 4]);
    end
`ifdef BCD_VALIDATE_EN
    e.err     = bad;
    e.chk_bin = 1'b1;
    e.bin     = bad ? '0 : BIN_W'(val);
    e.due     = bad ? k : k + BIN_W;
`else
    e.err     = 1'b0;
    e.chk_bin = !bad;
    e.bin     = BIN_W'(val);
    e.due     = k + BIN_W;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      checkOutput("done_width", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_item = sb.pop_front();
        checkOutput("done_cycle", 32'(cyc), 32'(mon_item.due));
        if (mon_item.chk_bin)
          checkOutput("bin_out", 32'(bin_out), 32'(mon_item.bin));
        checkOutput("err", 32'(err), 32'(mon_item.err));
      end
    end
    prev_done = done;
  end

  task automatic waitIdle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0)
      checkOutput("idle_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Drives a single-cycle start; returns #1 after the start edge.
  task automatic applyStimulus(input logic [4*DIGITS-1:0] bcd);
    waitIdle();
    bcd_in = bcd;
    start  = 1'b1;
    sb.push_back(expectedFor(bcd, cyc + 1));
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_bin"},  32'(bin_out), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy),    32'd0);
    checkOutput({tag, "_done"}, 32'(done),    32'd0);
    checkOutput({tag, "_err"},  32'(err),     32'd0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    prev_done    = 1'b0;
    rst_n        = 1'b0;
    start        = 1'b0;
    bcd_in       = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(8'h42);
    applyStimulus(8'h99);
    applyStimulus(8'h00);
    applyStimulus(8'hA5);
    applyStimulus(8'h07);

    // Extra start pulses and an input change while busy must be ignored.
    applyStimulus(8'h37);
    repeat (2) @(posedge clk);
    #1;
    start  = 1'b1;
    bcd_in = 8'h11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    // Reset mid-conversion: no expectation queued, so any done would be flagged.
    waitIdle();
    bcd_in = 8'h64;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("abort");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(8'h05);

    // start held high: accepted every BIN_W+2 edges.
    waitIdle();
    bcd_in = 8'h12;
    start  = 1'b1;
    for (int i = 0; i < 40; i += BIN_W + 2)
      sb.push_back(expectedFor(8'h12, cyc + 1 + i));
    repeat (40) @(posedge clk);
    #1;
    start = 1'b0;

    waitIdle();
    repeat (12) @(posedge clk);
    #1;
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
